// File: rtl/iter_mdu_alu.sv
// RV32IM execute unit: single-cycle base ALU plus an iterative (1 bit/cycle)
// shift-add multiplier and restoring divider behind valid/ready handshakes.
module iter_mdu_alu #(
  parameter int unsigned XLEN   = 32,
  parameter bit          EN_MDU = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int unsigned SW = $clog2(XLEN);
  localparam int unsigned AW = 2 * XLEN;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic [AW-1:0]     acc_q, acc_d;
  logic [XLEN-1:0]   opb_q, opb_d;
  logic [SW-1:0]     cnt_q, cnt_d;
  logic              is_div_q, is_div_d;
  logic              hi_q, hi_d;
  logic              neg_q, neg_d;

  // Base ALU decode
  logic [SW-1:0]   shamt;
  logic [XLEN-1:0] add_r, sub_r, sll_r, srl_r, sra_r, slt_r, sltu_r;
  logic [XLEN-1:0] base_res;

  assign shamt  = op_b[SW-1:0];
  assign add_r  = op_a + op_b;
  assign sub_r  = op_a - op_b;
  assign sll_r  = op_a << shamt;
  assign srl_r  = op_a >> shamt;
  assign sra_r  = XLEN'($signed(op_a) >>> shamt);
  assign slt_r  = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
  assign sltu_r = {{(XLEN-1){1'b0}}, (op_a < op_b)};

  always_comb begin
    base_res = '0;
    unique case (alu_op)
      2'b00: begin
        unique case (funct3)
          3'b000, 3'b010: base_res = add_r;
          3'b001:         base_res = sll_r;
          3'b011:         base_res = sltu_r;
          3'b100:         base_res = op_a ^ op_b;
          3'b101:         base_res = funct7[5] ? sra_r : srl_r;
          3'b110:         base_res = op_a | op_b;
          3'b111:         base_res = op_a & op_b;
          default:        base_res = '0;
        endcase
      end
      2'b01: base_res = sub_r;
      2'b10: begin
        if (funct7 == 7'b0000000) begin
          unique case (funct3)
            3'b000:  base_res = add_r;
            3'b001:  base_res = sll_r;
            3'b010:  base_res = slt_r;
            3'b011:  base_res = sltu_r;
            3'b100:  base_res = op_a ^ op_b;
            3'b101:  base_res = srl_r;
            3'b110:  base_res = op_a | op_b;
            3'b111:  base_res = op_a & op_b;
            default: base_res = '0;
          endcase
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'b000)      base_res = sub_r;
          else if (funct3 == 3'b101) base_res = sra_r;
        end
      end
      default: base_res = '0;
    endcase
  end

  // M-extension setup: signedness, magnitudes and single-cycle special cases
  logic            is_m, m_div, a_sgn, b_sgn, a_neg, b_neg, b_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag, special_res;

  assign is_m    = EN_MDU && (alu_op == 2'b10) && (funct7 == 7'b0000001);
  assign m_div   = funct3[2];
  assign a_sgn   = m_div ? ~funct3[0] : ((funct3 == 3'b001) || (funct3 == 3'b010));
  assign b_sgn   = m_div ? ~funct3[0] : (funct3 == 3'b001);
  assign a_neg   = a_sgn & op_a[XLEN-1];
  assign b_neg   = b_sgn & op_b[XLEN-1];
  assign a_mag   = a_neg ? (~op_a + XLEN'(1)) : op_a;
  assign b_mag   = b_neg ? (~op_b + XLEN'(1)) : op_b;
  assign b_zero  = (op_b == '0);
  assign div_ovf = ~funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);

  always_comb begin
    special_res = '0;
    if (b_zero)       special_res = funct3[1] ? op_a : '1;
    else if (div_ovf) special_res = funct3[1] ? '0 : op_a;
  end

  // One iteration step; acc holds {hi/rem, lo/quotient}
  logic [XLEN:0]   mul_sum, div_sh, div_diff;
  logic            div_ge;
  logic [AW-1:0]   step_mul, step_div, step;
  logic [AW-1:0]   prod;
  logic [XLEN-1:0] dsel, fin_res;

  assign mul_sum  = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign step_mul = {mul_sum, acc_q[XLEN-1:1]};
  assign div_sh   = {acc_q[AW-1:XLEN], acc_q[XLEN-1]};
  assign div_diff = div_sh - {1'b0, opb_q};
  assign div_ge   = ~div_diff[XLEN];
  assign step_div = {(div_ge ? div_diff[XLEN-1:0] : div_sh[XLEN-1:0]), acc_q[XLEN-2:0], div_ge};
  assign step     = is_div_q ? step_div : step_mul;

  assign prod = neg_q ? (~step + AW'(1)) : step;
  assign dsel = hi_q ? step[AW-1:XLEN] : step[XLEN-1:0];

  always_comb begin
    if (is_div_q) fin_res = neg_q ? (~dsel + XLEN'(1)) : dsel;
    else          fin_res = hi_q ? prod[AW-1:XLEN] : prod[XLEN-1:0];
  end

  // Next-state and datapath control
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    hi_d     = hi_q;
    neg_d    = neg_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (is_m && m_div && (b_zero || div_ovf)) begin
            result_d = special_res;
            state_d  = S_DONE;
          end else if (is_m) begin
            acc_d    = {{XLEN{1'b0}}, a_mag};
            opb_d    = b_mag;
            cnt_d    = '0;
            is_div_d = m_div;
            hi_d     = m_div ? funct3[1] : (funct3 != 3'b000);
            neg_d    = (m_div && funct3[1]) ? a_neg : (a_neg ^ b_neg);
            state_d  = S_CALC;
          end else begin
            result_d = base_res;
            state_d  = S_DONE;
          end
        end
      end
      S_CALC: begin
        acc_d = step;
        cnt_d = cnt_q + SW'(1);
        if (cnt_q == SW'(XLEN - 1)) begin
          result_d = fin_res;
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      hi_q     <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      hi_q     <= hi_d;
      neg_q    <= neg_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = (result_q == '0);

endmodule
